// File: rtl/cordic_pkg.sv
// Shared CORDIC accelerator definitions: control/status bit positions and controller states.
package cordic_pkg;

    localparam int p_CNTRL_START       = 0;
    localparam int p_CNTRL_ROT_MODE    = 1;
    localparam int p_CNTRL_ROT_SYS     = 2;
    localparam int p_CNTRL_ERR_INT_EN  = 3;
    localparam int p_CNTRL_RSLT_INT_EN = 4;
    localparam int p_CNTRL_OV_ST_EN    = 5;
    localparam int p_CNTRL_Z_OV_ST_EN  = 6;
    localparam int p_CNTRL_ITER_H      = 11;
    localparam int p_CNTRL_ITER_L      = 7;

    localparam int p_FLAG_READY        = 12;
    localparam int p_FLAG_INP_ERR      = 13;
    localparam int p_FLAG_OV_ERR       = 14;
    localparam int p_FLAG_X_OV         = 15;
    localparam int p_FLAG_Y_OV         = 16;
    localparam int p_FLAG_Z_OV         = 17;
    localparam int p_FLAG_OV_ITER_H    = 22;
    localparam int p_FLAG_OV_ITER_L    = 18;
    localparam int p_FLAG_ELAPSED_H    = 27;
    localparam int p_FLAG_ELAPSED_L    = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cordic_state_e;

endpackage

// File: rtl/cordic_shift_seq.sv
// Shift index for each CORDIC step; defining CORDIC_HYP_REPEAT_EN repeats hyperbolic shifts 4 and 13.
module cordic_shift_seq (
    input  logic [4:0] step,
    input  logic       rot_sys,
    output logic [4:0] shift
);

    always_comb begin
        // NOTE: default assignment first so every path drives shift and no latch is inferred.
        shift = step;
        if (!rot_sys) begin
`ifdef CORDIC_HYP_REPEAT_EN
            // Steps 4 and 14 are the repeats, so the index lags the step by one after 13.
            if (step < 5'd4) begin
                shift = step + 5'd1;
            end else if (step > 5'd13) begin
                shift = step - 5'd1;
            end
`else
            shift = step + 5'd1;
`endif
        end
    end

endmodule

// File: rtl/cordic_controller.sv
// CORDIC sequencing controller: latches bus operands, steps the core once per clock, reports status.
// Build option: CORDIC_HYP_REPEAT_EN (hyperbolic shift repeats, handled in cordic_shift_seq).
module cordic_controller
    import cordic_pkg::*;
#(
    parameter int p_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [p_WIDTH-1:0] xInput,
    input  logic [p_WIDTH-1:0] yInput,
    input  logic [p_WIDTH-1:0] zInput,
    input  logic [p_WIDTH-1:0] controlRegisterInput,
    output logic [p_WIDTH-1:0] xOutput,
    output logic [p_WIDTH-1:0] yOutput,
    output logic [p_WIDTH-1:0] zOutput,
    output logic [p_WIDTH-1:0] controlRegisterOutput,
    output logic               interrupt,
    output logic [p_WIDTH-1:0] xIn,
    output logic [p_WIDTH-1:0] yIn,
    output logic [p_WIDTH-1:0] zIn,
    output logic [p_WIDTH-1:0] angle,
    output logic [4:0]         shift,
    output logic               rotSystem,
    output logic               rotMode,
    input  logic [p_WIDTH-1:0] xOut,
    input  logic [p_WIDTH-1:0] yOut,
    input  logic [p_WIDTH-1:0] zOut,
    input  logic               xOv,
    input  logic               yOv,
    input  logic               zOv,
    output logic [4:0]         index,
    output logic               system,
    input  logic [p_WIDTH-1:0] lutAngle
);

    cordic_state_e state;
    logic [p_WIDTH-1:0] x_reg;
    logic [p_WIDTH-1:0] y_reg;
    logic [p_WIDTH-1:0] z_reg;
    logic [p_CNTRL_ITER_H:p_CNTRL_ROT_MODE] cfg;
    logic ready;
    logic inp_err;
    logic ov_err;
    logic x_ov;
    logic y_ov;
    logic z_ov;
    logic [4:0] ov_iter;
    logic [4:0] elapsed;
    logic [4:0] elapsed_nx;
    logic [4:0] iter;
    logic [4:0] start_iter;
    logic [4:0] seq_shift;
    logic       start;
    logic       run;
    logic       stop_ov;
    logic       first_ov;
    logic       unused_ctrl_bits;

    assign start      = controlRegisterInput[p_CNTRL_START];
    assign start_iter = controlRegisterInput[p_CNTRL_ITER_H:p_CNTRL_ITER_L];
    assign iter       = cfg[p_CNTRL_ITER_H:p_CNTRL_ITER_L];
    assign run        = (state == ST_RUN);
    assign elapsed_nx = elapsed + 5'd1;
    assign first_ov   = (xOv | yOv | zOv) & ~(x_ov | y_ov | z_ov);
    assign stop_ov    = ((xOv | yOv) & cfg[p_CNTRL_OV_ST_EN]) | (zOv & cfg[p_CNTRL_Z_OV_ST_EN]);
    assign unused_ctrl_bits = ^controlRegisterInput[p_WIDTH-1:p_CNTRL_ITER_H+1];

    cordic_shift_seq u_shift_seq (
        .step    (elapsed),
        .rot_sys (cfg[p_CNTRL_ROT_SYS]),
        .shift   (seq_shift)
    );

    // Core-facing step controls read zero outside RUN so the idle bus is quiet.
    assign shift     = run ? seq_shift : 5'd0;
    assign angle     = run ? lutAngle : '0;
    assign index     = shift;
    assign system    = cfg[p_CNTRL_ROT_SYS];
    assign rotSystem = cfg[p_CNTRL_ROT_SYS];
    assign rotMode   = cfg[p_CNTRL_ROT_MODE];
    assign xIn       = x_reg;
    assign yIn       = y_reg;
    assign zIn       = z_reg;
    assign xOutput   = x_reg;
    assign yOutput   = y_reg;
    assign zOutput   = z_reg;

    always_comb begin
        controlRegisterOutput = '0;
        controlRegisterOutput[p_CNTRL_ITER_H:p_CNTRL_ROT_MODE]   = cfg;
        controlRegisterOutput[p_FLAG_READY]                      = ready;
        controlRegisterOutput[p_FLAG_INP_ERR]                    = inp_err;
        controlRegisterOutput[p_FLAG_OV_ERR]                     = ov_err;
        controlRegisterOutput[p_FLAG_X_OV]                       = x_ov;
        controlRegisterOutput[p_FLAG_Y_OV]                       = y_ov;
        controlRegisterOutput[p_FLAG_Z_OV]                       = z_ov;
        controlRegisterOutput[p_FLAG_OV_ITER_H:p_FLAG_OV_ITER_L] = ov_iter;
        controlRegisterOutput[p_FLAG_ELAPSED_H:p_FLAG_ELAPSED_L] = elapsed;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            cfg       <= '0;
            ready     <= 1'b0;
            inp_err   <= 1'b0;
            ov_err    <= 1'b0;
            x_ov      <= 1'b0;
            y_ov      <= 1'b0;
            z_ov      <= 1'b0;
            ov_iter   <= '0;
            elapsed   <= '0;
            interrupt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_reg   <= xInput;
                        y_reg   <= yInput;
                        z_reg   <= zInput;
                        cfg     <= controlRegisterInput[p_CNTRL_ITER_H:p_CNTRL_ROT_MODE];
                        ov_err  <= 1'b0;
                        x_ov    <= 1'b0;
                        y_ov    <= 1'b0;
                        z_ov    <= 1'b0;
                        ov_iter <= '0;
                        elapsed <= '0;
                        if (start_iter == 5'd0) begin
                            state     <= ST_DONE;
                            ready     <= 1'b1;
                            inp_err   <= 1'b1;
                            interrupt <= controlRegisterInput[p_CNTRL_ERR_INT_EN];
                        end else begin
                            state     <= ST_RUN;
                            ready     <= 1'b0;
                            inp_err   <= 1'b0;
                            interrupt <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    x_reg   <= xOut;
                    y_reg   <= yOut;
                    z_reg   <= zOut;
                    elapsed <= elapsed_nx;
                    x_ov    <= x_ov | xOv;
                    y_ov    <= y_ov | yOv;
                    z_ov    <= z_ov | zOv;
                    // OV_ITER records the iteration number, i.e. ITER_ELAPSED once this step lands.
                    if (first_ov) begin
                        ov_iter <= elapsed_nx;
                    end
                    if (stop_ov) begin
                        state     <= ST_DONE;
                        ov_err    <= 1'b1;
                        ready     <= 1'b1;
                        interrupt <= cfg[p_CNTRL_ERR_INT_EN];
                    end else if (elapsed_nx == iter) begin
                        state     <= ST_DONE;
                        ready     <= 1'b1;
                        interrupt <= cfg[p_CNTRL_RSLT_INT_EN];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_controller.sv
// Self-checking bench for cordic_controller: behavioural core/LUT stand-ins, a step-level reference model and directed plus random runs.
module tb_cordic_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] xInput = '0;
    logic [31:0] yInput = '0;
    logic [31:0] zInput = '0;
    logic [31:0] controlRegisterInput = '0;
    logic [31:0] xOutput, yOutput, zOutput, controlRegisterOutput;
    logic        interrupt;
    logic [31:0] xIn, yIn, zIn, angle;
    logic [4:0]  shift;
    logic        rotSystem, rotMode;
    logic [31:0] xOut, yOut, zOut;
    logic        xOv, yOv, zOv;
    logic [4:0]  index;
    logic        system;
    logic [31:0] lutAngle;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    cordic_controller #(.p_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .xInput(xInput), .yInput(yInput), .zInput(zInput),
        .controlRegisterInput(controlRegisterInput),
        .xOutput(xOutput), .yOutput(yOutput), .zOutput(zOutput),
        .controlRegisterOutput(controlRegisterOutput),
        .interrupt(interrupt),
        .xIn(xIn), .yIn(yIn), .zIn(zIn), .angle(angle), .shift(shift),
        .rotSystem(rotSystem), .rotMode(rotMode),
        .xOut(xOut), .yOut(yOut), .zOut(zOut),
        .xOv(xOv), .yOv(yOv), .zOv(zOv),
        .index(index), .system(system), .lutAngle(lutAngle)
    );

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        xo;
        logic        yo;
        logic        zo;
    } core_res_t;

    // Stand-in angle table: any distinct value per (index, system) exposes a wrong index.
    function automatic logic [31:0] lut_fn(input logic [4:0] idx, input logic sys);
        return sys ? (32'h2000_0000 >> idx) : (32'h1A00_0000 >> idx);
    endfunction

    // One CORDIC micro-rotation with 33-bit sums; overflow when the result leaves 32 bits.
    function automatic core_res_t core_fn(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z, input logic [31:0] a,
                                          input logic [4:0] sh, input logic mode, input logic sys);
        logic signed [32:0] xe, ye, ze, ae, sx, sy, nx, ny, nz;
        logic      up;
        core_res_t r;
        xe = {x[31], x};
        ye = {y[31], y};
        ze = {z[31], z};
        ae = {a[31], a};
        sx = xe >>> sh;
        sy = ye >>> sh;
        up = mode ? !z[31] : y[31];
        if (sys) nx = up ? xe - sy : xe + sy;
        else     nx = up ? xe + sy : xe - sy;
        ny = up ? ye + sx : ye - sx;
        nz = up ? ze - ae : ze + ae;
        r.x  = nx[31:0];
        r.y  = ny[31:0];
        r.z  = nz[31:0];
        r.xo = nx[32] ^ nx[31];
        r.yo = ny[32] ^ ny[31];
        r.zo = nz[32] ^ nz[31];
        return r;
    endfunction

    core_res_t core_r;
    always_comb core_r = core_fn(xIn, yIn, zIn, angle, shift, rotMode, rotSystem);
    assign xOut = core_r.x;
    assign yOut = core_r.y;
    assign zOut = core_r.z;
    assign xOv  = core_r.xo;
    assign yOv  = core_r.yo;
    assign zOv  = core_r.zo;
    assign lutAngle = lut_fn(index, system);

    // Hyperbolic shift list built by enumeration; circular uses the step number itself.
    int hyp_tab[32];

    function automatic logic [4:0] shift_for(input logic sys, input int step);
        return sys ? 5'(step) : 5'(hyp_tab[step]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: operation-level state updated once per clock.
    logic        m_busy = 1'b0;
    logic [31:0] m_x = '0, m_y = '0, m_z = '0;
    logic [11:0] m_cfg = '0;
    logic        m_ready = 1'b0, m_inp = 1'b0, m_ove = 1'b0;
    logic        m_xo = 1'b0, m_yo = 1'b0, m_zo = 1'b0, m_int = 1'b0;
    logic [4:0]  m_oviter = '0;
    int          m_elapsed = 0;
    logic [4:0]  m_sh;
    core_res_t   m_r;
    logic        m_first, m_stop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_x = '0; m_y = '0; m_z = '0; m_cfg = '0;
            m_ready = 1'b0; m_inp = 1'b0; m_ove = 1'b0;
            m_xo = 1'b0; m_yo = 1'b0; m_zo = 1'b0; m_int = 1'b0;
            m_oviter = '0; m_elapsed = 0;
        end else if (m_busy) begin
            m_sh    = shift_for(m_cfg[2], m_elapsed);
            m_r     = core_fn(m_x, m_y, m_z, lut_fn(m_sh, m_cfg[2]), m_sh, m_cfg[1], m_cfg[2]);
            m_first = !(m_xo | m_yo | m_zo) && (m_r.xo | m_r.yo | m_r.zo);
            m_x = m_r.x; m_y = m_r.y; m_z = m_r.z;
            m_xo |= m_r.xo; m_yo |= m_r.yo; m_zo |= m_r.zo;
            m_elapsed++;
            if (m_first) m_oviter = 5'(m_elapsed);
            m_stop = ((m_r.xo | m_r.yo) && m_cfg[5]) || (m_r.zo && m_cfg[6]);
            if (m_stop) begin
                m_ove = 1'b1; m_ready = 1'b1; m_busy = 1'b0; m_int = m_cfg[3];
            end else if (m_elapsed == int'(m_cfg[11:7])) begin
                m_ready = 1'b1; m_busy = 1'b0; m_int = m_cfg[4];
            end
        end else if (controlRegisterInput[0]) begin
            m_x = xInput; m_y = yInput; m_z = zInput;
            m_cfg = controlRegisterInput[11:0] & 12'hFFE;
            m_ove = 1'b0; m_xo = 1'b0; m_yo = 1'b0; m_zo = 1'b0;
            m_oviter = '0; m_elapsed = 0;
            if (controlRegisterInput[11:7] == 5'd0) begin
                m_ready = 1'b1; m_inp = 1'b1; m_int = controlRegisterInput[3];
            end else begin
                m_ready = 1'b0; m_inp = 1'b0; m_int = 1'b0; m_busy = 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_ctrl();
        logic [31:0] w;
        w = '0;
        w[11:0]  = m_cfg;
        w[12]    = m_ready;
        w[13]    = m_inp;
        w[14]    = m_ove;
        w[15]    = m_xo;
        w[16]    = m_yo;
        w[17]    = m_zo;
        w[22:18] = m_oviter;
        w[27:23] = 5'(m_elapsed);
        return w;
    endfunction

    logic [4:0] c_sh;
    always @(negedge clk) begin
        if (chk_en) begin
            c_sh = m_busy ? shift_for(m_cfg[2], m_elapsed) : 5'd0;
            check("x_output", xOutput, m_x);
            check("y_output", yOutput, m_y);
            check("z_output", zOutput, m_z);
            check("ctrl_output", controlRegisterOutput, exp_ctrl());
            check("interrupt", 32'(interrupt), 32'(m_int));
            check("x_in", xIn, m_x);
            check("y_in", yIn, m_y);
            check("z_in", zIn, m_z);
            check("shift", 32'(shift), 32'(c_sh));
            check("index", 32'(index), 32'(c_sh));
            check("angle", angle, m_busy ? lut_fn(c_sh, m_cfg[2]) : 32'h0);
            check("rot_mode", 32'(rotMode), 32'(m_cfg[1]));
            check("rot_system", 32'(rotSystem), 32'(m_cfg[2]));
            check("system", 32'(system), 32'(m_cfg[2]));
        end
    end

    task automatic start_op(input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] z, input logic [31:0] cfg);
        @(negedge clk); #1;
        xInput = x; yInput = y; zInput = z;
        controlRegisterInput = cfg | 32'h1;
        @(posedge clk); #1;
        controlRegisterInput = cfg & ~32'h1;
    endtask

    // Waits for READY, optionally poking START mid-run; an expired bound counts as a failure.
    task automatic wait_done(input int max_cycles, input bit poke, output int cycles);
        logic [31:0] base;
        base = controlRegisterInput;
        cycles = 0;
        while (!controlRegisterOutput[12] && cycles < max_cycles) begin
            if (poke && $urandom_range(0, 5) == 0) begin
                controlRegisterInput = $urandom | 32'h1;
                xInput = $urandom;
            end
            @(posedge clk); #1;
            controlRegisterInput = base;
            cycles++;
        end
        if (!controlRegisterOutput[12]) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: READY still %b after %0d cycles, required 1", controlRegisterOutput[12], cycles);
        end
    endtask

    initial begin
        int s, n, cnt, it;
        logic [31:0] cfg, rx, ry, rz;

        n = 0;
        s = 1;
        while (n < 32) begin
            hyp_tab[n] = s;
            n++;
`ifdef CORDIC_HYP_REPEAT_EN
            if ((s == 4 || s == 13) && n < 32) begin
                hyp_tab[n] = s;
                n++;
            end
`endif
            s++;
        end

        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_ctrl", controlRegisterOutput, 32'h0);
        check("reset_x", xOutput, 32'h0);
        check("reset_int", 32'(interrupt), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Circular rotation, one step: shift 0 and angle 0x2000_0000.
        start_op(32'h100, 32'h0, 32'h0, 32'h96);
        wait_done(40, 1'b0, cnt);
        check("iter1_edges", cnt, 32'd1);
        check("iter1_x", xOutput, 32'h0000_0100);
        check("iter1_y", yOutput, 32'h0000_0100);
        check("iter1_z", zOutput, 32'hE000_0000);
        check("iter1_ctrl", controlRegisterOutput, 32'h0080_1096);
        check("iter1_int", 32'(interrupt), 32'h1);

        // ITER=0 flags an input error on the START edge.
        start_op(32'h1, 32'h2, 32'h3, 32'h8);
        check("inp_err_ctrl", controlRegisterOutput, 32'h0000_3008);
        check("inp_err_int", 32'(interrupt), 32'h1);
        check("inp_err_x", xOutput, 32'h1);

        // Hyperbolic rotation begins at shift 1.
        start_op(32'h4000_0000, 32'h1000_0000, 32'h0, 32'h292);
        check("hyp_shift0", 32'(shift), 32'h1);
        check("hyp_index0", 32'(index), 32'h1);
        wait_done(40, 1'b0, cnt);
        check("hyp_edges", cnt, 32'd5);
        check("hyp_int", 32'(interrupt), 32'h1);

        // X overflow on the first step stops the run with OV_ERR.
        start_op(32'h6000_0000, 32'h6000_0000, 32'h0, 32'hF2C);
        wait_done(40, 1'b0, cnt);
        check("ov_edges", cnt, 32'd1);
        check("ov_ctrl", controlRegisterOutput, 32'h0084_DF2C);
        check("ov_x", xOutput, 32'hC000_0000);
        check("ov_z", zOutput, 32'h2000_0000);
        check("ov_int", 32'(interrupt), 32'h1);

        // Normal completion with the result interrupt disabled.
        start_op(32'h1000, 32'h800, 32'h0, 32'h404);
        wait_done(40, 1'b0, cnt);
        check("noint_edges", cnt, 32'd8);
        check("noint_int", 32'(interrupt), 32'h0);
        check("noint_err", 32'(controlRegisterOutput[14:13]), 32'h0);

        // Reset at edge 10 of a 20-step run, then a clean run.
        start_op(32'h0123_4567, 32'h0012_3456, 32'h0, 32'hA16);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_ctrl", controlRegisterOutput, 32'h0);
        check("midrst_x", xOutput, 32'h0);
        check("midrst_int", 32'(interrupt), 32'h0);
        check("midrst_shift", 32'(shift), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        start_op(32'h2000, 32'h1000, 32'h0, 32'h216);
        wait_done(40, 1'b0, cnt);
        check("postrst_edges", cnt, 32'd4);
        check("postrst_int", 32'(interrupt), 32'h1);

        for (int op = 0; op < 60; op++) begin
            it  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
            cfg = ($urandom & 32'hFFFF_F07E) | (32'(it) << 7);
            rx  = 32'($signed(32'($urandom)) >>> $urandom_range(0, 6));
            ry  = 32'($signed(32'($urandom)) >>> $urandom_range(0, 6));
            rz  = 32'($signed(32'($urandom)) >>> $urandom_range(0, 3));
            start_op(rx, ry, rz, cfg);
            wait_done(80, 1'b1, cnt);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
